// File: rtl/x_mem_play_ctrl_if.sv
// Host write handshake into the playback controller: valid/ready with address and data.
// The loader drives master, the controller is the slave.
interface x_mem_play_ctrl_if #(
    parameter int AW = 11,
    parameter int DW = 2
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/x_mem_play_ctrl.sv
// Arbiter and sequencer for a single-port 2048x2 sample RAM: host writes share the port
// with a rate-divided looping playback reader that has fixed priority.
module x_mem_play_ctrl #(
    parameter int DIV_W = 16,
    parameter int AW    = 11,
    parameter int DW    = 2
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    x_mem_play_ctrl_if.slave wr,
    input  logic             i_play_en,
    input  logic [AW-1:0]    i_play_last,
    input  logic [DIV_W-1:0] i_div,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_we,
    output logic [DW-1:0]    o_mem_wdata,
    input  logic [DW-1:0]    i_mem_rdata,
    output logic             o_smp_valid,
    output logic [DW-1:0]    o_smp_data,
    output logic             o_wrap,
    output logic             o_busy
);
    typedef enum logic [0:0] {IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    last_q;
    logic             tick;
    logic             rd_slot;
    logic             rd_v1;
    logic             wrap1;

    assign tick    = (state == RUN) && (div_cnt == i_div);
    assign rd_slot = tick && i_play_en;
    assign o_busy  = (state == RUN);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        // NOTE: all clocked state uses non-blocking assignment so every register sees
        // pre-edge values regardless of block ordering.
        if (!i_nrst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        case (state)
            IDLE: if (i_play_en)  state_nxt = RUN;
            RUN:  if (!i_play_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The read slot steals the RAM port; the host write simply waits for the next free cycle.
    always_comb begin
        o_mem_addr  = wr.wr_addr;
        o_mem_we    = wr.wr_valid;
        o_mem_wdata = wr.wr_data;
        wr.wr_ready = 1'b1;
        if (rd_slot) begin
            o_mem_addr  = rd_ptr;
            o_mem_we    = 1'b0;
            wr.wr_ready = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            div_cnt <= '0;
            rd_ptr  <= '0;
            last_q  <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            if (i_play_en) begin
                rd_ptr <= '0;
                last_q <= i_play_last;
            end
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
            if (rd_slot) rd_ptr <= (rd_ptr == last_q) ? '0 : rd_ptr + PTR_ONE;
        end
    end

    // Two-stage read pipeline: RAM output is valid one cycle after the slot, then registered.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_v1       <= 1'b0;
            wrap1       <= 1'b0;
            o_smp_valid <= 1'b0;
            o_smp_data  <= '0;
            o_wrap      <= 1'b0;
        end else begin
            rd_v1       <= rd_slot;
            wrap1       <= rd_slot && (rd_ptr == last_q);
            o_smp_valid <= rd_v1;
            o_wrap      <= rd_v1 && wrap1;
            if (rd_v1) o_smp_data <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_x_mem_play_ctrl.sv
// Directed bench for x_mem_play_ctrl with a behavioural read-first RAM model.
module tb_x_mem_play_ctrl;
    localparam int AW    = 11;
    localparam int DW    = 2;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             play_en = 1'b0;
    logic [AW-1:0]    play_last = '0;
    logic [DIV_W-1:0] div = '0;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata = '0;
    logic             smp_valid;
    logic [DW-1:0]    smp_data;
    logic             wrap;
    logic             busy;
    logic [DW-1:0]    ram [2048];

    int checks = 0;
    int errors = 0;

    x_mem_play_ctrl_if #(.AW(AW), .DW(DW)) wr ();

    x_mem_play_ctrl #(.DIV_W(DIV_W), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_nrst(rst_n), .wr(wr.slave),
        .i_play_en(play_en), .i_play_last(play_last), .i_div(div),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
        .o_smp_valid(smp_valid), .o_smp_data(smp_data), .o_wrap(wrap), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with registered output.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        wr.wr_valid = 1'b0; wr.wr_addr = '0; wr.wr_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", smp_valid); end
        checks++; if (smp_data !== 2'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", smp_data); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b exp 0", wrap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", wr.wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            wr.wr_valid = 1'b1; wr.wr_addr = AW'(k); wr.wr_data = DW'(k % 4);
            #1;
            checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL load_ready k=%0d got %0b exp 1", k, wr.wr_ready); end
            checks++; if (mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_wdata !== DW'(k % 4)) begin
                errors++; $display("FAIL load_pins k=%0d got we=%0b a=%0d d=%0d exp we=1 a=%0d d=%0d", k, mem_we, mem_addr, mem_wdata, k, k % 4);
            end
            checks++; if (smp_valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
                errors++; $display("FAIL load_idle k=%0d got v=%0b b=%0b w=%0b exp 0", k, smp_valid, busy, wrap);
            end
        end
        @(negedge clk);
        wr.wr_valid = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (ram[k] !== DW'(k % 4)) begin errors++; $display("FAIL load_ram a=%0d got %0d exp %0d", k, ram[k], k % 4); end
        end
    endtask

    task automatic test_playback();
        logic is_rd, is_v;
        @(negedge clk);
        play_last = 11'd3; div = 16'd2; play_en = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3) play_last = 11'd1;  // must be ignored until next start
            #1;
            is_rd = (k >= 2) && ((k - 2) % 3 == 0);
            is_v  = (k >= 4) && ((k - 4) % 3 == 0);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL play_busy k=%0d got %0b exp 1", k, busy); end
            checks++; if (wr.wr_ready !== !is_rd) begin errors++; $display("FAIL play_ready k=%0d got %0b exp %0b", k, wr.wr_ready, !is_rd); end
            if (is_rd) begin
                checks++; if (mem_addr !== AW'(((k - 2) / 3) % 4) || mem_we !== 1'b0) begin
                    errors++; $display("FAIL play_addr k=%0d got a=%0d we=%0b exp a=%0d we=0", k, mem_addr, mem_we, ((k - 2) / 3) % 4);
                end
            end
            checks++; if (smp_valid !== is_v) begin errors++; $display("FAIL play_valid k=%0d got %0b exp %0b", k, smp_valid, is_v); end
            if (is_v) begin
                checks++; if (smp_data !== DW'(((k - 4) / 3) % 4)) begin errors++; $display("FAIL play_data k=%0d got %0d exp %0d", k, smp_data, ((k - 4) / 3) % 4); end
                checks++; if (wrap !== (((k - 4) / 3) == 3)) begin errors++; $display("FAIL play_wrap k=%0d got %0b exp %0b", k, wrap, ((k - 4) / 3) == 3); end
            end
        end
        @(negedge clk);
        play_en = 1'b0; play_last = 11'd3;
        #1;
        checks++; if (wr.wr_ready !== 1'b1) begin errors++; $display("FAIL stop_ready got %0b exp 1", wr.wr_ready); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %0b exp 0", busy); end
        checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL stop_valid got %0b exp 0", smp_valid); end
    endtask

    task automatic test_contention();
        int  idx = 0;
        logic exp_rdy;
        @(negedge clk);
        div = 16'd3; play_last = 11'd7; play_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wr.wr_valid = 1'b1; wr.wr_addr = AW'(100 + idx); wr.wr_data = DW'((idx % 3) + 1);
            #1;
            exp_rdy = (k % 4 != 3);
            checks++; if (wr.wr_ready !== exp_rdy) begin errors++; $display("FAIL cont_ready k=%0d got %0b exp %0b", k, wr.wr_ready, exp_rdy); end
            checks++; if (mem_we !== exp_rdy) begin errors++; $display("FAIL cont_we k=%0d got %0b exp %0b", k, mem_we, exp_rdy); end
            if (wr.wr_ready === 1'b1) idx++;
        end
        @(negedge clk);
        wr.wr_valid = 1'b0; play_en = 1'b0;
        checks++; if (idx !== 15) begin errors++; $display("FAIL cont_count got %0d exp 15", idx); end
        @(negedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            checks++; if (ram[100 + i] !== DW'((i % 3) + 1)) begin errors++; $display("FAIL cont_ram a=%0d got %0d exp %0d", 100 + i, ram[100 + i], (i % 3) + 1); end
        end
        checks++; if (ram[115] !== 2'd0) begin errors++; $display("FAIL cont_extra a=115 got %0d exp 0", ram[115]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy got %0b exp 0", busy); end
    endtask

    task automatic test_starve();
        @(negedge clk);
        wr.wr_valid = 1'b1; wr.wr_addr = 11'd0; wr.wr_data = 2'd3;
        @(negedge clk);
        wr.wr_valid = 1'b0; div = 16'd0; play_last = 11'd0; play_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wr.wr_valid = 1'b1; wr.wr_addr = 11'd200; wr.wr_data = 2'd2;
            #1;
            checks++; if (wr.wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 11'd0) begin
                errors++; $display("FAIL starve_pins k=%0d got r=%0b we=%0b a=%0d exp r=0 we=0 a=0", k, wr.wr_ready, mem_we, mem_addr);
            end
            checks++; if (smp_valid !== (k >= 2)) begin errors++; $display("FAIL starve_valid k=%0d got %0b exp %0b", k, smp_valid, k >= 2); end
            if (k >= 2) begin
                checks++; if (smp_data !== 2'd3 || wrap !== 1'b1) begin
                    errors++; $display("FAIL starve_data k=%0d got d=%0d w=%0b exp d=3 w=1", k, smp_data, wrap);
                end
            end
        end
        @(negedge clk);
        play_en = 1'b0;
        #1;
        checks++; if (wr.wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd200) begin
            errors++; $display("FAIL starve_release got r=%0b we=%0b a=%0d exp r=1 we=1 a=200", wr.wr_ready, mem_we, mem_addr);
        end
        @(negedge clk);
        wr.wr_valid = 1'b0;
        #1;
        checks++; if (ram[200] !== 2'd2) begin errors++; $display("FAIL starve_ram got %0d exp 2", ram[200]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_busy got %0b exp 0", busy); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_drop_and_reset();
        @(negedge clk);
        div = 16'd1; play_last = 11'd7; play_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 2) play_en = 1'b0;
            #1;
            if (k == 1) begin
                checks++; if (wr.wr_ready !== 1'b0 || mem_addr !== 11'd0) begin errors++; $display("FAIL drop_read got r=%0b a=%0d exp r=0 a=0", wr.wr_ready, mem_addr); end
            end
            if (k == 2) begin
                checks++; if (busy !== 1'b1 || wr.wr_ready !== 1'b1) begin errors++; $display("FAIL drop_noread got b=%0b r=%0b exp b=1 r=1", busy, wr.wr_ready); end
            end
            if (k == 3) begin
                checks++; if (smp_valid !== 1'b1 || smp_data !== 2'd3) begin errors++; $display("FAIL drop_last got v=%0b d=%0d exp v=1 d=3", smp_valid, smp_data); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b exp 0", busy); end
            end
            if (k >= 4) begin
                checks++; if (smp_valid !== 1'b0 || wr.wr_ready !== 1'b1) begin errors++; $display("FAIL drop_quiet k=%0d got v=%0b r=%0b exp v=0 r=1", k, smp_valid, wr.wr_ready); end
            end
        end
        @(negedge clk);
        play_en = 1'b1;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j == 2) begin rst_n = 1'b0; play_en = 1'b0; end
            if (j == 4) rst_n = 1'b1;
            #1;
            if (j == 1) begin
                checks++; if (wr.wr_ready !== 1'b0 || mem_addr !== 11'd0) begin errors++; $display("FAIL restart_addr got r=%0b a=%0d exp r=0 a=0", wr.wr_ready, mem_addr); end
            end
            if (j >= 2) begin
                checks++; if (smp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid j=%0d got %0b exp 0", j, smp_valid); end
                checks++; if (smp_data !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_state j=%0d got d=%0d b=%0b exp d=0 b=0", j, smp_data, busy); end
            end
        end
        @(negedge clk);
        div = 16'd0; play_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checks++; if (wr.wr_ready !== 1'b0 || mem_addr !== AW'(k)) begin errors++; $display("FAIL rst_ptr k=%0d got r=%0b a=%0d exp r=0 a=%0d", k, wr.wr_ready, mem_addr, k); end
        end
        @(negedge clk);
        play_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        test_reset();
        test_load();
        test_playback();
        test_contention();
        test_starve();
        test_drop_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
